// File: rtl/rd_data2b_if.sv
// Purpose: groups the memory read port, AES core handshake and status lines of rd_data2b.
// Latency: none, plain wiring bundle.
// Backpressure: none; the feeder waits only on aes_done.
interface rd_data2b_if;
  logic         start;
  logic         en_r_datamem;
  logic [31:0]  addr_rd;
  logic [31:0]  data_rd;
  logic [127:0] plaintext_out;
  logic [127:0] key_out;
  logic         aes_start;
  logic         aes_done;
  logic         busy;
  logic         done;

  // Feeder side: drives the memory read port and the AES launch.
  modport master (
    input  start, data_rd, aes_done,
    output en_r_datamem, addr_rd, plaintext_out, key_out, aes_start, busy, done
  );

  // Environment side: memory, AES core and the sequencer issuing start.
  modport slave (
    output start, data_rd, aes_done,
    input  en_r_datamem, addr_rd, plaintext_out, key_out, aes_start, busy, done
  );
endinterface

// File: rtl/rd_data2b.sv
// Purpose: fetch 4 plaintext + 4 key words from data memory, pack to 128-bit blocks, launch AES.
// Latency: reads in cycles 1-8 after start, aes_start in cycle 10, done one cycle after aes_done.
// Backpressure: holds both blocks in WAIT_AES until aes_done; start is ignored while busy.
module rd_data2b #(
  parameter logic [31:0] PT_BASE   = 32'd400,
  parameter logic [31:0] KEY_BASE  = 32'd450,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic      clk,
  input  logic      reset,
  rd_data2b_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_LAUNCH, S_WAIT_AES, S_FIN
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_rd_idx, w_rd_idx_nxt;
  logic         r_cap_vld;
  logic [2:0]   r_cap_idx;

  logic         r_en, r_aes_start, r_busy, r_done;
  logic [31:0]  r_addr;
  logic [127:0] r_pt, r_key;

  logic         w_en_nxt, w_aes_start_nxt, w_busy_nxt, w_done_nxt;
  logic [31:0]  w_addr_nxt;

  // State register: current state and the read index being presented this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rd_idx <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_idx <= w_rd_idx_nxt;
    end
  end

  // Next-state logic; the read index wraps 7->0 as FETCH hands over to DRAIN.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_idx_nxt = r_rd_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = S_FETCH;
          w_rd_idx_nxt = 3'd0;
        end
      end
      S_FETCH: begin
        w_rd_idx_nxt = r_rd_idx + 3'd1;
        if (r_rd_idx == 3'd7) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:    w_state_nxt = S_LAUNCH;
      S_LAUNCH:   w_state_nxt = S_WAIT_AES;
      S_WAIT_AES: if (bus.aes_done) w_state_nxt = S_FIN;
      S_FIN:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with r_state.
  always_comb begin
    w_en_nxt        = (w_state_nxt == S_FETCH);
    w_aes_start_nxt = (w_state_nxt == S_LAUNCH);
    w_done_nxt      = (w_state_nxt == S_FIN);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_addr_nxt      = 32'd0;
    if (w_en_nxt) begin
      // Indices 4..7 reuse the low two bits as the key word offset.
      if (w_rd_idx_nxt[2])
        w_addr_nxt = KEY_BASE + {30'd0, w_rd_idx_nxt[1:0]} * ADDR_STEP;
      else
        w_addr_nxt = PT_BASE + {30'd0, w_rd_idx_nxt[1:0]} * ADDR_STEP;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en        <= 1'b0;
      r_addr      <= 32'd0;
      r_aes_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_en        <= w_en_nxt;
      r_addr      <= w_addr_nxt;
      r_aes_start <= w_aes_start_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Capture data_rd one cycle after each read; word 0 lands in the MSBs of its block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= 3'd0;
      r_pt      <= 128'd0;
      r_key     <= 128'd0;
    end else begin
      r_cap_vld <= r_en;
      r_cap_idx <= r_rd_idx;
      if (r_cap_vld) begin
        if (r_cap_idx[2])
          r_key[{~r_cap_idx[1:0], 5'd0} +: 32] <= bus.data_rd;
        else
          r_pt[{~r_cap_idx[1:0], 5'd0} +: 32] <= bus.data_rd;
      end
    end
  end

  assign bus.en_r_datamem  = r_en;
  assign bus.addr_rd       = r_addr;
  assign bus.plaintext_out = r_pt;
  assign bus.key_out       = r_key;
  assign bus.aes_start     = r_aes_start;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_rd_data2b.sv
// Purpose: directed self-checking bench for rd_data2b, plus a second instance with a wrapping base.
// Latency: checks outputs 1 time unit after each rising edge, cycle numbers relative to start.
// Backpressure: aes_done is driven directly at chosen cycles by the stimulus.
module tb_rd_data2b;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  rd_data2b_if u_if ();
  rd_data2b_if u_wif ();

  rd_data2b u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  rd_data2b #(.PT_BASE(32'hFFFF_FFF8)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (u_wif.master)
  );

  logic [31:0]  exp_addr [8];
  logic [31:0]  wrap_addr [5];
  logic [127:0] exp_pt;
  logic [127:0] exp_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'd400: mem_rd = 32'h0011_2233;
      32'd404: mem_rd = 32'h4455_6677;
      32'd408: mem_rd = 32'h8899_AABB;
      32'd412: mem_rd = 32'hCCDD_EEFF;
      32'd450: mem_rd = 32'h0001_0203;
      32'd454: mem_rd = 32'h0405_0607;
      32'd458: mem_rd = 32'h0809_0A0B;
      32'd462: mem_rd = 32'h0C0D_0E0F;
      default: mem_rd = 32'hBAD0_0000 ^ a;
    endcase
  endfunction

  // Synchronous-read memory: data for an address appears the cycle after it is presented.
  always @(posedge clk) begin
    u_if.data_rd  <= u_if.en_r_datamem  ? mem_rd(u_if.addr_rd)  : 32'hDEAD_BEEF;
    u_wif.data_rd <= u_wif.en_r_datamem ? mem_rd(u_wif.addr_rd) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full sequence starting in cycle 1, aes_done at cycle 15, done expected at 16.
  task automatic run_normal(input string tag, input bit with_wrap);
    for (int c = 1; c <= 17; c++) begin
      u_if.start    = 1'b0;
      u_wif.start   = 1'b0;
      u_if.aes_done = (c == 15);
      chk({tag, "_en"}, 128'(u_if.en_r_datamem), 128'(c <= 8));
      chk({tag, "_addr"}, 128'(u_if.addr_rd), (c <= 8) ? 128'(exp_addr[c-1]) : 128'd0);
      chk({tag, "_aes_start"}, 128'(u_if.aes_start), 128'(c == 10));
      chk({tag, "_done"}, 128'(u_if.done), 128'(c == 16));
      chk({tag, "_busy"}, 128'(u_if.busy), 128'(c <= 16));
      if (c == 10 || c == 17) begin
        chk({tag, "_pt"}, u_if.plaintext_out, exp_pt);
        chk({tag, "_key"}, u_if.key_out, exp_key);
      end
      if (with_wrap && c <= 5)
        chk("wrap_addr", 128'(u_wif.addr_rd), 128'(wrap_addr[c-1]));
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_addr  = '{32'd400, 32'd404, 32'd408, 32'd412, 32'd450, 32'd454, 32'd458, 32'd462};
    wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'd450};
    exp_pt  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_key = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    reset          = 1'b0;
    u_if.start     = 1'b0;
    u_if.aes_done  = 1'b0;
    u_wif.start    = 1'b0;
    u_wif.aes_done = 1'b1;
    repeat (2) tick();

    chk("rst_en", 128'(u_if.en_r_datamem), 128'd0);
    chk("rst_addr", 128'(u_if.addr_rd), 128'd0);
    chk("rst_pt", u_if.plaintext_out, 128'd0);
    chk("rst_key", u_if.key_out, 128'd0);
    chk("rst_aes_start", 128'(u_if.aes_start), 128'd0);
    chk("rst_busy", 128'(u_if.busy), 128'd0);
    chk("rst_done", 128'(u_if.done), 128'd0);

    reset = 1'b1;
    repeat (2) tick();

    // Normal run, wrap instance launched alongside.
    u_if.start  = 1'b1;
    u_wif.start = 1'b1;
    tick();
    run_normal("normal", 1'b1);

    // Start while busy plus spurious aes_done in FETCH and LAUNCH.
    u_if.start = 1'b1;
    tick();
    for (int c = 1; c <= 15; c++) begin
      u_if.start    = (c == 4 || c == 12);
      u_if.aes_done = (c == 3 || c == 10 || c == 12);
      if (c <= 8) chk("busy_addr", 128'(u_if.addr_rd), 128'(exp_addr[c-1]));
      chk("busy_aes_start", 128'(u_if.aes_start), 128'(c == 10));
      chk("busy_done", 128'(u_if.done), 128'(c == 13));
      chk("busy_busy", 128'(u_if.busy), 128'(c <= 13));
      tick();
    end
    u_if.start    = 1'b0;
    u_if.aes_done = 1'b0;

    // Reset mid-fetch, then a clean rerun.
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (4) tick();
    chk("mid_en_pre", 128'(u_if.en_r_datamem), 128'd1);
    reset = 1'b0;
    #1;
    chk("mid_en", 128'(u_if.en_r_datamem), 128'd0);
    chk("mid_addr", 128'(u_if.addr_rd), 128'd0);
    chk("mid_pt", u_if.plaintext_out, 128'd0);
    chk("mid_key", u_if.key_out, 128'd0);
    chk("mid_busy", 128'(u_if.busy), 128'd0);
    chk("mid_start_done", 128'({u_if.aes_start, u_if.done}), 128'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("mid_idle", 128'(u_if.busy), 128'd0);
    u_if.start = 1'b1;
    tick();
    run_normal("rerun", 1'b0);

    // Start held high: back-to-back runs separated by one IDLE cycle.
    u_if.start = 1'b1;
    tick();
    for (int c = 1; c <= 29; c++) begin
      u_if.start    = (c <= 15);
      u_if.aes_done = (c == 12 || c == 26);
      if (c <= 8) chk("held_addr1", 128'(u_if.addr_rd), 128'(exp_addr[c-1]));
      if (c >= 15 && c <= 22) chk("held_addr2", 128'(u_if.addr_rd), 128'(exp_addr[c-15]));
      chk("held_aes_start", 128'(u_if.aes_start), 128'(c == 10 || c == 24));
      chk("held_done", 128'(u_if.done), 128'(c == 13 || c == 27));
      chk("held_busy", 128'(u_if.busy), 128'(!(c == 14 || c >= 28)));
      if (c == 24) chk("held_pt2", u_if.plaintext_out, exp_pt);
      tick();
    end
    u_if.start    = 1'b0;
    u_if.aes_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
